spart_bus_arbiter: RTL and testbench

//  Shares the single SPART processor-side bus (iocs/iorw/ioaddr/databus) between two

---
 rtl/spart_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_spart_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_arbiter.sv
// Two-client arbiter and access sequencer for the SPART processor-side bus.
// Round-robin between clients, with a lock held across the baud-divisor pair and a per-access timeout.
module spart_bus_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] we,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] ack,
    output logic       err,
    output logic [7:0] rdata,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] timer_q, timer_d;
    logic        rr_q, rr_d;
    logic        lock_q, lock_d;
    logic        lock_own_q, lock_own_d;
    logic [1:0]  hold_q, hold_d;
    logic [1:0]  ack_q, ack_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;

    logic [1:0]  elig;
    logic        grant;
    logic        ready;
    logic        expired;
    logic [1:0]  owner_oh;

    assign owner_oh = owner_q ? 2'b10 : 2'b01;

    always_comb begin
        elig = req & ~hold_q;
        if (lock_q)
            elig = elig & (lock_own_q ? 2'b10 : 2'b01);
        grant   = (elig == 2'b11) ? rr_q : elig[1];
        // Only the data register has flow control; status and divisor regs are always ready.
        ready   = (addr_q == 2'b00) ? (we_q ? tbr : rda) : 1'b1;
        expired = (TIMEOUT != 16'd0) && (timer_q == TIMEOUT - 16'd1);

        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        timer_d    = timer_q;
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        hold_d     = 2'b00;
        ack_d      = 2'b00;
        err_d      = 1'b0;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (elig != 2'b00) begin
                    state_d = S_PEND;
                    owner_d = grant;
                    we_d    = we[grant];
                    addr_d  = grant ? addr1 : addr0;
                    wdata_d = grant ? wdata1 : wdata0;
                    timer_d = 16'd0;
                end
            end
            S_PEND: begin
                if (ready) begin
                    state_d = S_XFER;
                end else begin
                    timer_d = timer_q + 16'd1;
                    if (expired) begin
                        state_d = S_DONE;
                        ack_d   = owner_oh;
                        err_d   = 1'b1;
                        if (lock_q && (lock_own_q == owner_q))
                            lock_d = 1'b0;
                    end
                end
            end
            S_XFER: begin
                state_d = S_DONE;
                ack_d   = owner_oh;
                if (!we_q) begin
                    rdata_d = databus;
                end else if (addr_q == 2'b10) begin
                    lock_d     = 1'b1;
                    lock_own_d = owner_q;
                end else if ((addr_q == 2'b11) && lock_q && (lock_own_q == owner_q)) begin
                    lock_d = 1'b0;
                end
            end
            default: begin
                // Holdoff masks the finished client for one IDLE cycle so a held req is not re-issued.
                state_d = S_IDLE;
                rr_d    = ~owner_q;
                hold_d  = owner_oh;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 2'b00;
            wdata_q    <= 8'h00;
            timer_q    <= 16'd0;
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
            hold_q     <= 2'b00;
            ack_q      <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            timer_q    <= timer_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            hold_q     <= hold_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign iocs    = (state_q == S_XFER);
    assign iorw    = iocs ? ~we_q : 1'b1;
    assign ioaddr  = iocs ? addr_q : 2'b01;
    assign databus = (iocs && we_q) ? wdata_q : 8'hzz;
    assign ack     = ack_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Bench for spart_bus_arbiter: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed latencies, arbitration order, lock, timeout and reset.
module tb_spart_bus_arbiter;

    localparam int TO = 12;

    typedef struct { logic we; logic [1:0] addr; logic [7:0] wd; } cmd_t;
    typedef struct { int cyc; logic rw; logic [1:0] a; logic [7:0] d; } bus_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_r = 2'b00;
    logic [1:0] we_r = 2'b00;
    logic [1:0] addr_r [2];
    logic [7:0] wd_r [2];
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic [7:0] sp_val = 8'h00;
    logic [1:0] ack;
    logic       err;
    logic [7:0] rdata;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;

    logic [1:0] req8 = 2'b00;
    logic [1:0] ack8;
    logic       err8;
    logic [7:0] rdata8;
    logic       iocs8, iorw8;
    logic [1:0] ioaddr8;
    wire  [7:0] databus8;

    // Bench-side SPART: drives the bus whenever the arbiter is not writing.
    assign databus  = (iocs && !iorw) ? 8'hzz : sp_val;
    assign databus8 = (iocs8 && !iorw8) ? 8'hzz : 8'h00;

    spart_bus_arbiter #(.TIMEOUT(16'(TO))) dut (
        .clk(clk), .rst(rst), .req(req_r), .we(we_r),
        .addr0(addr_r[0]), .addr1(addr_r[1]), .wdata0(wd_r[0]), .wdata1(wd_r[1]),
        .ack(ack), .err(err), .rdata(rdata), .rda(rda), .tbr(tbr),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus)
    );

    spart_bus_arbiter #(.TIMEOUT(16'd8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .we(2'b10),
        .addr0(2'b00), .addr1(2'b00), .wdata0(8'h00), .wdata1(8'h33),
        .ack(ack8), .err(err8), .rdata(rdata8), .rda(1'b0), .tbr(1'b0),
        .iocs(iocs8), .iorw(iorw8), .ioaddr(ioaddr8), .databus(databus8)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   cmp_en = 1'b0;
    cmd_t cq [2][$];
    int   ackq [2][$];
    bit   errq [2][$];
    logic [7:0] rdq [2][$];
    bus_t busq [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_ack(input int c, input int n, input string nm);
        int t = 0;
        while (ackq[c].size() < n && t < 100) begin @(posedge clk); #2; t++; end
        chk(nm, 32'(ackq[c].size() >= n), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Clients: present the head of their command queue, pop it the cycle after its ack.
    initial begin
        logic [1:0] a;
        addr_r[0] = 2'b01; addr_r[1] = 2'b01; wd_r[0] = 8'h00; wd_r[1] = 8'h00;
        forever begin
            @(negedge clk);
            a = ack;
            for (int c = 0; c < 2; c++)
                if (a[c]) begin ackq[c].push_back(cyc); errq[c].push_back(err); rdq[c].push_back(rdata); end
            if (iocs) busq.push_back('{cyc, iorw, ioaddr, databus});
            @(posedge clk); #1;
            for (int c = 0; c < 2; c++) begin
                if (a[c] && cq[c].size() > 0) void'(cq[c].pop_front());
                if (cq[c].size() > 0) begin
                    req_r[c]  = 1'b1;
                    we_r[c]   = cq[c][0].we;
                    addr_r[c] = cq[c][0].addr;
                    wd_r[c]   = cq[c][0].wd;
                end else begin
                    req_r[c] = 1'b0;
                end
            end
        end
    end

    // Reference model: one outstanding access record; phase 0 idle, 1 waiting, 2 on bus, 3 acking.
    int         m_ph = 0, m_waited = 0;
    bit         m_own = 0, m_we = 0, m_rr = 0, m_lock = 0, m_lown = 0, m_err = 0;
    bit  [1:0]  m_addr = 0, m_hold = 0;
    logic [7:0] m_wd = 0, m_rdata = 0;

    initial forever begin
        bit [1:0] e;
        bit       w;
        @(posedge clk);
        if (rst) begin
            m_ph = 0; m_rr = 0; m_lock = 0; m_lown = 0; m_hold = 0; m_rdata = 0; m_err = 0;
        end else begin
            case (m_ph)
                0: begin
                    e = req_r & ~m_hold;
                    if (m_lock) e = e & (2'b01 << m_lown);
                    m_hold = 0;
                    if (e != 0) begin
                        w = (e == 2'b11) ? m_rr : (e == 2'b10);
                        m_own = w; m_we = we_r[w]; m_addr = addr_r[w]; m_wd = wd_r[w];
                        m_waited = 0; m_ph = 1;
                    end
                end
                1: begin
                    if (m_addr != 0 || (m_we ? tbr : rda)) m_ph = 2;
                    else begin
                        m_waited++;
                        if (TO != 0 && m_waited == TO) begin
                            m_ph = 3; m_err = 1;
                            if (m_lock && m_lown == m_own) m_lock = 0;
                        end
                    end
                end
                2: begin
                    if (!m_we) m_rdata = sp_val;
                    else if (m_addr == 2) begin m_lock = 1; m_lown = m_own; end
                    else if (m_addr == 3 && m_lock && m_lown == m_own) m_lock = 0;
                    m_err = 0; m_ph = 3;
                end
                default: begin
                    m_rr = !m_own; m_hold = 2'b01 << m_own; m_ph = 0;
                end
            endcase
        end
    end

    initial forever begin
        logic [7:0] eb;
        @(negedge clk);
        if (cmp_en) begin
            eb = (m_ph == 2 && m_we) ? m_wd : sp_val;
            chk("cycle", {9'd0, ack, err, rdata, iocs, iorw, ioaddr, databus},
                {9'd0, (m_ph == 3) ? (2'b01 << m_own) : 2'b00, m_ph == 3 && m_err, m_rdata,
                 m_ph == 2, !(m_ph == 2 && m_we), (m_ph == 2) ? m_addr : 2'b01, eb});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, nb, base, at;
        bit hit, e8;
        logic [1:0] a8;

        step(1);
        cmp_en = 1'b1;
        chk("reset_state", {ack, err, rdata, iocs, iorw, ioaddr}, {2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01});
        step(2); rst = 1'b0; step(1);

        // single write to data register with tbr high
        tbr = 1'b1; nb = busq.size(); n0 = ackq[0].size(); base = cyc + 1;
        cq[0].push_back('{1'b1, 2'b00, 8'h41});
        wait_ack(0, n0 + 1, "t1_ack");
        chk("t1_latency", ackq[0][n0] - base, 3);
        chk("t1_buscount", busq.size() - nb, 1);
        chk("t1_bus", {busq[nb].rw, busq[nb].a, busq[nb].d}, {1'b0, 2'b00, 8'h41});
        chk("t1_err", 32'(errq[0][n0]), 0);
        step(2);

        // timeout on the TIMEOUT=8 instance
        req8 = 2'b10; hit = 0; at = -1; e8 = 0; a8 = 0;
        for (int i = 0; i < 20 && at < 0; i++) begin
            @(negedge clk);
            if (iocs8) hit = 1;
            if (ack8 != 2'b00) begin at = i; a8 = ack8; e8 = err8; end
        end
        @(posedge clk); #2; req8 = 2'b00;
        chk("t4_latency", at, 9);
        chk("t4_ack", a8, 2'b10);
        chk("t4_err", 32'(e8), 1);
        chk("t4_no_iocs", 32'(hit), 0);
        chk("t4_rdata", rdata8, 8'h00);

        // simultaneous requests from reset; client 0 holds req for a second access
        rst = 1'b1; step(2); rst = 1'b0; step(1);
        sp_val = 8'h11; n0 = ackq[0].size(); n1 = ackq[1].size(); base = cyc + 1;
        cq[0].push_back('{1'b0, 2'b01, 8'h00});
        cq[0].push_back('{1'b0, 2'b01, 8'h00});
        cq[1].push_back('{1'b0, 2'b01, 8'h00});
        wait_ack(0, n0 + 2, "t2_ack0");
        wait_ack(1, n1 + 1, "t2_ack1");
        chk("t2_c0_first", ackq[0][n0] - base, 3);
        chk("t2_c1_second", ackq[1][n1] - base, 7);
        chk("t2_c0_held", ackq[0][n0 + 1] - base, 11);
        step(2);
        n0 = ackq[0].size(); n1 = ackq[1].size(); base = cyc + 1;
        cq[0].push_back('{1'b0, 2'b01, 8'h00});
        cq[1].push_back('{1'b0, 2'b01, 8'h00});
        wait_ack(0, n0 + 1, "t2b_ack0");
        wait_ack(1, n1 + 1, "t2b_ack1");
        chk("t2b_c1_first", ackq[1][n1] - base, 3);
        chk("t2b_c0_second", ackq[0][n0] - base, 7);
        step(2);

        // read data register, rda low for 10 cycles
        sp_val = 8'h5A; rda = 1'b0; n0 = ackq[0].size(); nb = busq.size(); base = cyc + 1;
        cq[0].push_back('{1'b0, 2'b00, 8'h00});
        step(10);
        chk("t3_no_iocs_wait", busq.size() - nb, 0);
        rda = 1'b1;
        wait_ack(0, n0 + 1, "t3_ack");
        rda = 1'b0;
        chk("t3_latency", ackq[0][n0] - base, 11);
        chk("t3_rdata", rdq[0][n0], 8'h5A);
        step(2);

        // timeout on the main instance (TIMEOUT=12)
        n1 = ackq[1].size(); nb = busq.size(); base = cyc + 1;
        cq[1].push_back('{1'b0, 2'b00, 8'h00});
        wait_ack(1, n1 + 1, "to_ack");
        chk("to_latency", ackq[1][n1] - base, 13);
        chk("to_err", 32'(errq[1][n1]), 1);
        chk("to_no_bus", busq.size() - nb, 0);
        step(2);

        // divisor pair stays atomic against a pending client 1
        tbr = 1'b1; sp_val = 8'h77; n0 = ackq[0].size(); n1 = ackq[1].size(); nb = busq.size();
        base = cyc + 1;
        cq[0].push_back('{1'b1, 2'b10, 8'h8A});
        cq[0].push_back('{1'b1, 2'b11, 8'h02});
        step(1);
        cq[1].push_back('{1'b0, 2'b01, 8'h00});
        wait_ack(0, n0 + 2, "t5_ack0");
        wait_ack(1, n1 + 1, "t5_ack1");
        chk("t5_c1_latency", ackq[1][n1] - base, 12);
        chk("t5_order", 32'(ackq[1][n1] > ackq[0][n0 + 1]), 1);
        chk("t5_buscount", busq.size() - nb, 3);
        chk("t5_bus0", {busq[nb].rw, busq[nb].a, busq[nb].d}, {1'b0, 2'b10, 8'h8A});
        chk("t5_bus1", {busq[nb + 1].rw, busq[nb + 1].a, busq[nb + 1].d}, {1'b0, 2'b11, 8'h02});
        chk("t5_bus2", {busq[nb + 2].rw, busq[nb + 2].a, busq[nb + 2].d}, {1'b1, 2'b01, 8'h77});
        step(2);

        // reset during XFER with lock held by client 0
        n0 = ackq[0].size();
        cq[0].push_back('{1'b1, 2'b10, 8'h55});
        wait_ack(0, n0 + 1, "t6_lock_ack");
        step(2);
        n0 = ackq[0].size();
        cq[0].push_back('{1'b1, 2'b00, 8'h66});
        step(3);
        chk("t6_in_xfer", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b00, 8'h66});
        rst = 1'b1; cq[0].delete();
        step(1);
        chk("t6_released", {iocs, iorw, ioaddr, ack, err}, {1'b1 ^ 1'b1, 1'b1, 2'b01, 2'b00, 1'b0});
        chk("t6_bus_z", databus, sp_val);
        rst = 1'b0;
        step(3);
        chk("t6_no_ack", ackq[0].size() - n0, 0);
        n0 = ackq[0].size(); n1 = ackq[1].size(); base = cyc + 1;
        cq[0].push_back('{1'b0, 2'b01, 8'h00});
        cq[1].push_back('{1'b0, 2'b01, 8'h00});
        wait_ack(0, n0 + 1, "t6_ack0");
        wait_ack(1, n1 + 1, "t6_ack1");
        chk("t6_rr_reset", ackq[0][n0] - base, 3);
        chk("t6_lock_reset", ackq[1][n1] - base, 7);

        step(3);
        chk("queues_empty", cq[0].size() + cq[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
